// File: rtl/adc_lvds_ser_model.sv
// Serial-LVDS ADC emulator: per-channel MSB-first lanes, frame clock and ENC lock detection on DCO.
// Optional test-pattern modes (fixed, ramp, alternating) are built only when ADC_SER_TESTPAT_EN is defined.
module adc_lvds_ser_model #(
    parameter int CHANNELS   = 4,
    parameter int BITS       = 14,
    parameter int FRAME_BITS = 16,
    parameter int LOAD_POS   = 7,
    parameter int SYNC_DLY   = 0
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       ENC,
    input  logic [CHANNELS*BITS-1:0]   DATA_IN,
    input  logic [1:0]                 MODE,
    input  logic [BITS-1:0]            PATTERN,
    output logic                       FCO,
    output logic [CHANNELS-1:0]        DATA_OUT,
    output logic                       LOAD,
    output logic                       LOCKED,
    output logic [15:0]                FRAME_CNT
);

    localparam int CW  = $clog2(FRAME_BITS);
    localparam int PW  = $clog2(2*FRAME_BITS+1);
    localparam int PAD = FRAME_BITS - BITS;

    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS-1);
    localparam logic [CW-1:0] CNT_HALF = CW'(FRAME_BITS/2);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LOAD_POS);
    localparam logic [CW-1:0] CNT_SYNC = CW'(SYNC_DLY);
    localparam logic [PW-1:0] PC_MATCH = PW'(FRAME_BITS-1);
    localparam logic [PW-1:0] PC_TMOUT = PW'(2*FRAME_BITS);

    typedef enum logic [1:0] {ST_UNLOCK, ST_CHECK, ST_LOCKED} lock_state_t;

    logic [1:0]    enc_s_q;
    logic          enc_edge;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fco_q;
    logic [15:0]   frame_cnt_q;
    logic [PW-1:0] pc_q, pc_d;
    lock_state_t   state_q, state_d;

    // ENC rising edge as seen two CLK cycles late through the synchroniser
    assign enc_edge = enc_s_q[0] & ~enc_s_q[1];

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        if (enc_edge) begin
            cnt_d = CNT_SYNC;
        end
    end

    // Gated by RST_N so LOAD stays low while in reset whatever LOAD_POS is
    assign LOAD = RST_N && (cnt_q == CNT_LOAD);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            enc_s_q     <= '0;
            cnt_q       <= '0;
            fco_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            enc_s_q <= {enc_s_q[0], ENC};
            cnt_q   <= cnt_d;
            fco_q   <= (cnt_d >= CNT_HALF);
            if (LOAD) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign FCO       = fco_q;
    assign FRAME_CNT = frame_cnt_q;

    always_comb begin
        state_d = state_q;
        pc_d    = (pc_q == PC_TMOUT) ? pc_q : pc_q + 1'b1;
        if (enc_edge) begin
            pc_d = '0;
        end
        case (state_q)
            ST_UNLOCK: if (enc_edge) state_d = ST_CHECK;
            ST_CHECK:  if (enc_edge && pc_q == PC_MATCH) state_d = ST_LOCKED;
            ST_LOCKED: begin
                if (enc_edge ? (pc_q != PC_MATCH) : (pc_q == PC_TMOUT)) begin
                    state_d = ST_UNLOCK;
                end
            end
            default:   state_d = ST_UNLOCK;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_UNLOCK;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign LOCKED = (state_q == ST_LOCKED);

`ifdef ADC_SER_TESTPAT_EN
    logic [BITS-1:0] ramp_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ramp_q <= '0;
        end else if (LOAD) begin
            ramp_q <= ramp_q + BITS'(1);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{MODE, PATTERN};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
            logic [BITS-1:0]       word;
            logic [FRAME_BITS-1:0] sr_q, sr_d;

`ifdef ADC_SER_TESTPAT_EN
            always_comb begin
                case (MODE)
                    2'd1:    word = PATTERN;
                    2'd2:    word = ramp_q + BITS'(gi);
                    2'd3:    word = frame_cnt_q[0] ? ~PATTERN : PATTERN;
                    default: word = DATA_IN[gi*BITS +: BITS];
                endcase
            end
`else
            assign word = DATA_IN[gi*BITS +: BITS];
`endif

            always_comb begin
                if (LOAD) begin
                    sr_d = FRAME_BITS'(word) << PAD;
                end else begin
                    sr_d = {sr_q[FRAME_BITS-2:0], 1'b0};
                end
            end

            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= sr_d;
                end
            end

            assign DATA_OUT[gi] = sr_q[FRAME_BITS-1];
        end
    endgenerate

endmodule
